// File: rtl/la_adder_pkg.sv
// Shared definitions for the LA-driven sequential adder/subtractor:
// FSM state encoding and bit positions on the LA and IO buses.
package la_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // la_data_in fields
    localparam int A_LSB     = 0;
    localparam int B_LSB     = 32;
    localparam int START_BIT = 64;
    localparam int MODE_BIT  = 65;
    localparam int CLEAR_BIT = 66;

    // la_data_out fields
    localparam int RES_LSB   = 0;
    localparam int CARRY_BIT = 32;
    localparam int BUSY_BIT  = 33;
    localparam int DONE_BIT  = 34;
    localparam int CNT_LSB   = 35;

    // io_out status word (checkbits)
    localparam int IO_SIG_LSB   = 24;
    localparam int IO_DONE_BIT  = 23;
    localparam int IO_BUSY_BIT  = 22;
    localparam int IO_CARRY_BIT = 21;
    localparam int IO_CNT_LSB   = 16;

endpackage

// File: rtl/la_adder_seq_chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // One ripple slice; widened by one bit so the carry-out falls out of the add.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/la_adder_seq.sv
// Sequential add/subtract driven from the logic-analyzer port. One CHUNK-bit
// slice is added per cycle; subtraction is A + ~B + 1 with the raw carry-out
// reported (1 = no borrow). Results and status return on la_data_out and io_out.
module la_adder_seq
    import la_adder_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter int          CHUNK = 4,
    parameter logic [7:0]  SIG   = 8'hAB
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    // Control bits only count when the firmware has enabled them (oenb low).
    logic start_g, clear_g, mode_g, rise;
    assign start_g = la_data_in[START_BIT] & ~la_oenb[START_BIT];
    assign clear_g = la_data_in[CLEAR_BIT] & ~la_oenb[CLEAR_BIT];
    assign mode_g  = la_data_in[MODE_BIT]  & ~la_oenb[MODE_BIT];

    // Operand bits and the upper LA lanes carry no enable semantics here.
    logic unused_la;
    assign unused_la = ^{la_data_in[127:67], la_oenb[127:67], la_oenb[63:0]};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
    logic              carry_q, carry_d, done_q, done_d, irq_q, irq_d, start_q;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;

    assign rise = start_g & ~start_q;

    // Current slice of both operands, selected by the running index.
    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;
    assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state logic: clear overrides everything, then start/slice steps.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        done_d   = done_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        irq_d    = 1'b0;
        if (clear_g) begin
            result_d = '0;
            carry_d  = 1'b0;
            done_d   = 1'b0;
            idx_d    = '0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (rise) begin
                        a_d      = la_data_in[A_LSB +: WIDTH];
                        b_d      = mode_g ? ~la_data_in[B_LSB +: WIDTH] : la_data_in[B_LSB +: WIDTH];
                        carry_d  = mode_g;
                        idx_d    = '0;
                        result_d = '0;
                        done_d   = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_d[idx_q*CHUNK +: CHUNK] = slice_sum;
                    carry_d = slice_cout;
                    idx_d   = idx_q + IDXW'(1);
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 8'd1;
                        irq_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            irq_q    <= irq_d;
            start_q  <= start_g;
        end
    end

    logic busy;
    assign busy = (state_q == ST_RUN);

    // Output assembly; every field comes straight from a register.
    always_comb begin
        la_data_out = '0;
        la_data_out[RES_LSB +: WIDTH] = result_q;
        la_data_out[CARRY_BIT]        = carry_q;
        la_data_out[BUSY_BIT]         = busy;
        la_data_out[DONE_BIT]         = done_q;
        la_data_out[CNT_LSB +: 8]     = cnt_q;

        io_out = '0;
        io_out[IO_SIG_LSB +: 8]  = SIG;
        io_out[IO_DONE_BIT]      = done_q;
        io_out[IO_BUSY_BIT]      = busy;
        io_out[IO_CARRY_BIT]     = carry_q;
        io_out[IO_CNT_LSB +: 4]  = cnt_q[3:0];
    end

    assign io_oeb = 38'h3F_0000_FFFF;
    assign irq    = {2'b00, irq_q};

endmodule

// File: tb/tb_la_adder_seq.sv
// Self-checking bench for la_adder_seq: directed cases plus random operations
// compared against a plain-arithmetic reference.
module tb_la_adder_seq;

    localparam int NCHUNK = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    int n_checks = 0;
    int n_fail   = 0;
    int total_ops = 0;
    logic [7:0] exp_cnt = 8'd0;

    la_adder_seq dut (
        .clock       (clk),
        .resetb      (rst_n),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 32-bit arithmetic; sub carry is 1 when no borrow.
    function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (sub) return {(a >= b), a - b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [127:0] exp_word(input logic [32:0] r, input logic done, input logic busy, input logic [7:0] cnt);
        return {85'b0, cnt, done, busy, r[32], r[31:0]};
    endfunction

    function automatic logic [37:0] exp_io(input logic done, input logic busy, input logic carry, input logic [7:0] cnt);
        return {6'b0, 8'hAB, done, busy, carry, 1'b0, cnt[3:0], 16'b0};
    endfunction

    // {busy, done, irq[0]}
    function automatic logic [2:0] st();
        return {la_data_out[33], la_data_out[34], irq[0]};
    endfunction

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic sub);
        la_data_in[31:0]  = a;
        la_data_in[63:32] = b;
        la_data_in[65]    = sub;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] r;
        logic        bad;
        r = ref_op(a, b, sub);
        bad = 1'b0;
        @(negedge clk);
        set_ops(a, b, sub);
        la_data_in[64] = 1'b1;
        @(negedge clk);
        check("busy_after_start", {125'b0, st()}, 128'b100);
        for (int i = 1; i < NCHUNK; i++) begin
            @(negedge clk);
            if (st() !== 3'b100) bad = 1'b1;
        end
        check("busy_hold", {127'b0, bad}, 128'b0);
        @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total_ops++;
        check("done_status", {125'b0, st()}, 128'b011);
        check("result_word", la_data_out, exp_word(r, 1'b1, 1'b0, exp_cnt));
        la_data_in[64] = 1'b0;
        @(negedge clk);
        check("irq_single", {125'b0, irq}, 128'b0);
    endtask

    initial begin
        logic [32:0] r1;
        logic        seen;
        la_data_in = '0;
        la_oenb    = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset_io_status", {112'b0, io_out[31:16]}, 128'hAB00);
        check("reset_io_out", {90'b0, io_out}, {90'b0, exp_io(0, 0, 0, 0)});
        check("reset_la_out", la_data_out, 128'b0);
        check("reset_irq", {125'b0, irq}, 128'b0);
        check("io_oeb", {90'b0, io_oeb}, {90'b0, 38'h3F_0000_FFFF});

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        set_ops(32'h1234_5678, 32'h1111_1111, 1'b0);
        la_data_in[64] = 1'b1;
        repeat (3) @(negedge clk);
        la_data_in[64] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_la", la_data_out, 128'b0);
        check("async_reset_io", {90'b0, io_out}, {90'b0, exp_io(0, 0, 0, 0)});
        @(negedge clk);
        rst_n = 1'b1;

        // Add with full carry ripple
        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("add_checkbits", {112'b0, io_out[31:16]}, 128'hABA1);

        // Subtract both directions
        do_op(32'd5, 32'd7, 1'b1);
        do_op(32'd7, 32'd5, 1'b1);

        // Second rise while running is ignored; held start does not retrigger
        r1 = ref_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);
        set_ops(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        la_data_in[64] = 1'b1;
        @(negedge clk);
        la_data_in[64] = 1'b0;
        @(negedge clk);
        set_ops(32'h1111_1111, 32'h2222_2222, 1'b1);
        la_data_in[64] = 1'b1;
        repeat (NCHUNK - 1) @(negedge clk);
        exp_cnt = exp_cnt + 8'd1;
        total_ops++;
        check("run_rise_ignored", la_data_out, exp_word(r1, 1'b1, 1'b0, exp_cnt));
        repeat (3) @(negedge clk);
        check("held_start_no_retrigger", {125'b0, st()}, 128'b010);
        la_data_in[64] = 1'b0;

        // Clear mid-operation aborts with no irq and keeps op_count
        @(negedge clk);
        set_ops(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        la_data_in[64] = 1'b1;
        repeat (4) @(negedge clk);
        la_data_in[66] = 1'b1;
        @(negedge clk);
        check("clear_mid_op", la_data_out, exp_word(33'b0, 1'b0, 1'b0, exp_cnt));
        check("clear_irq", {125'b0, irq}, 128'b0);
        la_data_in[66] = 1'b0;
        la_data_in[64] = 1'b0;
        seen = 1'b0;
        repeat (NCHUNK + 2) begin
            @(negedge clk);
            if (irq[0] !== 1'b0 || la_data_out[33] !== 1'b0) seen = 1'b1;
        end
        check("clear_no_late_irq", {127'b0, seen}, 128'b0);

        // Clear and rise together: clear wins, start is lost
        la_data_in[64] = 1'b1;
        la_data_in[66] = 1'b1;
        @(negedge clk);
        check("clear_rise_same", {125'b0, st()}, 128'b000);
        la_data_in[66] = 1'b0;
        @(negedge clk);
        check("clear_rise_lost", {125'b0, st()}, 128'b000);
        la_data_in[64] = 1'b0;
        @(negedge clk);

        // Masked start does nothing
        la_oenb[64] = 1'b1;
        la_data_in[64] = 1'b1;
        repeat (2) @(negedge clk);
        check("masked_start", la_data_out, exp_word(33'b0, 1'b0, 1'b0, exp_cnt));
        la_data_in[64] = 1'b0;
        la_oenb[64] = 1'b0;

        // Random operations up to 256 completions, exercising op_count wrap
        while (total_ops < 256) begin
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        check("cnt_wrap", {120'b0, la_data_out[42:35]}, 128'b0);
        check("io_cnt_wrap", {124'b0, io_out[19:16]}, 128'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
